// File: rtl/pcler8_pkg.sv
// Shared types and constants for the pcler8 loadable, cascadable counter.
package pcler8_pkg;

  localparam int unsigned PCLER8_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ONESHOT = 1'b0,
    AUTO    = 1'b1
  } mode_e;

endpackage

// File: rtl/pcler8_next.sv
// Combinational next-value logic: FSM state, counter, reload value, mode and terminal count.
module pcler8_next
  import pcler8_pkg::*;
#(
  parameter int unsigned WIDTH = PCLER8_WIDTH
) (
  input  state_e             state_i,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   rld_i,
  input  mode_e              mode_i,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               cin_i,
  input  logic [WIDTH-1:0]   ld_data_i,
  input  mode_e              ld_mode_i,
  output state_e             state_o,
  output logic [WIDTH-1:0]   q_o,
  output logic [WIDTH-1:0]   rld_o,
  output mode_e              mode_o,
  output logic               cout_o
);

  logic all_ones_s;
  logic step_s;

  assign all_ones_s = (q_i == {WIDTH{1'b1}});
  assign step_s     = (state_i == RUN) & en_i & cin_i;
  assign cout_o     = step_s & all_ones_s;

  // Priority: clear, then load accept, then count; otherwise hold.
  always_comb begin
    state_o = state_i;
    q_o     = q_i;
    rld_o   = rld_i;
    mode_o  = mode_i;
    if (clr_i) begin
      state_o = IDLE;
      q_o     = {WIDTH{1'b0}};
      rld_o   = {WIDTH{1'b0}};
      mode_o  = ONESHOT;
    end else if (load_i) begin
      state_o = RUN;
      q_o     = ld_data_i;
      rld_o   = ld_data_i;
      mode_o  = ld_mode_i;
    end else if (step_s) begin
      if (all_ones_s) begin
        if (mode_i == AUTO) begin
          q_o = rld_i;
        end else begin
          q_o     = {WIDTH{1'b0}};
          state_o = DONE;
        end
      end else begin
        q_o = q_i + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      q_o = q_i;
    end
  end

endmodule

// File: rtl/pcler8_ctrl.sv
// Loadable up-counter with one-shot/auto-reload modes and a cascade carry chain.
module pcler8_ctrl
  import pcler8_pkg::*;
#(
  parameter int unsigned WIDTH = PCLER8_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_auto,
  input  logic             clr,
  input  logic             en,
  input  logic             cin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  mode_e            mode_q, mode_d;
  logic             tc_q;
  logic             load_s;
  logic             cout_s;

  // Loads are refused while running and whenever a clear is pending.
  assign ld_ready = (state_q != RUN) & ~clr;
  assign load_s   = ld_valid & ld_ready;

  pcler8_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .state_i   (state_q),
    .q_i       (q_q),
    .rld_i     (rld_q),
    .mode_i    (mode_q),
    .load_i    (load_s),
    .clr_i     (clr),
    .en_i      (en),
    .cin_i     (cin),
    .ld_data_i (ld_data),
    .ld_mode_i (mode_e'(ld_auto)),
    .state_o   (state_d),
    .q_o       (q_d),
    .rld_o     (rld_d),
    .mode_o    (mode_d),
    .cout_o    (cout_s)
  );

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= {WIDTH{1'b0}};
      rld_q   <= {WIDTH{1'b0}};
      mode_q  <= ONESHOT;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      mode_q  <= mode_d;
      tc_q    <= cout_s & ~clr;
    end
  end

  assign q        = q_q;
  assign cout     = cout_s;
  assign tc_pulse = tc_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_pcler8_ctrl.sv
// Directed bench for pcler8_ctrl: two cascaded instances checked every cycle against a behavioural model.
module tb_pcler8_ctrl;

  typedef struct {
    int q;
    int rld;
    bit auto_m;
    int st;   // 0 idle, 1 run, 2 done
    bit tc;
  } mdl_t;

  logic       clk;
  logic       rst, clr, en, cin;
  logic       ld_valid, ld_auto, ld_valid1, ld_auto1;
  logic [7:0] ld_data, ld_data1;
  logic       ld_ready0, cout0, tc0, busy0, done0;
  logic       ld_ready1, cout1, tc1, busy1, done1;
  logic [7:0] q0, q1;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk     = 1'b0;
  mdl_t m0, m1;

  pcler8_ctrl #(.WIDTH(8)) u_lo (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready0), .ld_data(ld_data),
    .ld_auto(ld_auto), .clr(clr), .en(en), .cin(cin), .q(q0), .cout(cout0),
    .tc_pulse(tc0), .busy(busy0), .done(done0)
  );

  pcler8_ctrl #(.WIDTH(8)) u_hi (
    .clk(clk), .rst(rst), .ld_valid(ld_valid1), .ld_ready(ld_ready1), .ld_data(ld_data1),
    .ld_auto(ld_auto1), .clr(clr), .en(en), .cin(cout0), .q(q1), .cout(cout1),
    .tc_pulse(tc1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_cout(mdl_t s, bit e, bit ci);
    return (s.st == 1) && e && ci && (s.q == 255);
  endfunction

  function automatic mdl_t m_next(mdl_t s, bit r, bit c, bit lv, int ld, bit la, bit e, bit ci);
    mdl_t n;
    n    = s;
    n.tc = m_cout(s, e, ci);
    if (r) begin
      n.q = 0; n.rld = 0; n.auto_m = 0; n.st = 0; n.tc = 0;
    end else if (c) begin
      n.q = 0; n.rld = 0; n.auto_m = 0; n.st = 0; n.tc = 0;
    end else if (lv && s.st != 1) begin
      n.q = ld; n.rld = ld; n.auto_m = la; n.st = 1;
    end else if (s.st == 1 && e && ci) begin
      if (s.q == 255) begin
        if (s.auto_m) n.q = s.rld;
        else begin n.q = 0; n.st = 2; end
      end else begin
        n.q = (s.q + 1) % 256;
      end
    end
    return n;
  endfunction

  task automatic cmp(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_x(string name, logic [7:0] act, int exp);
    n_tests++;
    if ($isunknown(act) || act !== 8'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model, then advance one clock.
  task automatic step();
    bit c0;
    #1;
    if (chk) begin
      c0 = m_cout(m0, en, cin);
      cmp_x("q0", q0, m0.q);
      cmp_x("cout0", {7'd0, cout0}, int'(c0));
      cmp_x("tc0", {7'd0, tc0}, int'(m0.tc));
      cmp_x("busy0", {7'd0, busy0}, int'(m0.st == 1));
      cmp_x("done0", {7'd0, done0}, int'(m0.st == 2));
      cmp_x("ld_ready0", {7'd0, ld_ready0}, int'(m0.st != 1 && !clr));
      cmp_x("q1", q1, m1.q);
      cmp_x("cout1", {7'd0, cout1}, int'(m_cout(m1, en, c0)));
      cmp_x("tc1", {7'd0, tc1}, int'(m1.tc));
      cmp_x("busy1", {7'd0, busy1}, int'(m1.st == 1));
      cmp_x("done1", {7'd0, done1}, int'(m1.st == 2));
      cmp_x("ld_ready1", {7'd0, ld_ready1}, int'(m1.st != 1 && !clr));
    end
    @(posedge clk);
    c0 = m_cout(m0, en, cin);
    m0 = m_next(m0, rst, clr, ld_valid, int'(ld_data), ld_auto, en, cin);
    m1 = m_next(m1, rst, clr, ld_valid1, int'(ld_data1), ld_auto1, en, c0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; cin = 1'b0;
    ld_valid = 1'b0; ld_auto = 1'b0; ld_data = 8'h00;
    ld_valid1 = 1'b0; ld_auto1 = 1'b0; ld_data1 = 8'h00;
    m0 = '{0, 0, 1'b0, 0, 1'b0};
    m1 = '{0, 0, 1'b0, 0, 1'b0};
    @(negedge clk);
    step();
    chk = 1'b1;
    step();
    cmp("rst_q", int'(q0), 0);
    cmp("rst_ready", int'(ld_ready0), 1);
    cmp("rst_busy", int'(busy0), 0);

    // One-shot from 0xFC
    rst = 1'b0; ld_valid = 1'b1; ld_data = 8'hFC; ld_auto = 1'b0; en = 1'b1; cin = 1'b1;
    step();
    ld_valid = 1'b0;
    cmp("os_q_fc", int'(q0), 8'hFC);
    step(); cmp("os_q_fd", int'(q0), 8'hFD);
    step(); cmp("os_q_fe", int'(q0), 8'hFE);
    step(); cmp("os_q_ff", int'(q0), 8'hFF); cmp("os_cout", int'(cout0), 1);
    step(); cmp("os_q_00", int'(q0), 0); cmp("os_tc", int'(tc0), 1); cmp("os_done", int'(done0), 1);
    step(); cmp("os_tc_once", int'(tc0), 0);

    // Auto-reload from 0xFE
    ld_valid = 1'b1; ld_data = 8'hFE; ld_auto = 1'b1;
    step();
    ld_valid = 1'b0;
    cmp("ar_q_fe", int'(q0), 8'hFE);
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("ar_busy", int'(busy0), 1);
    end
    cmp("ar_q_end", int'(q0), 8'hFE);

    // Carry-in gating and load refused in RUN
    clr = 1'b1; step(); clr = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h0F; ld_auto = 1'b0; step(); ld_valid = 1'b0;
    step(); cmp("cin_q_10", int'(q0), 8'h10);
    step(); cmp("cin_q_11", int'(q0), 8'h11);
    cin = 1'b0; ld_valid = 1'b1; ld_data = 8'h55; #1;
    cmp("run_ready", int'(ld_ready0), 0);
    step(); cmp("cin_hold", int'(q0), 8'h11);
    cin = 1'b1; ld_valid = 1'b0;
    step(); cmp("cin_q_12", int'(q0), 8'h12);

    // Clear beats load and terminal count at 0xFF
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b0; ld_valid = 1'b1; ld_data = 8'hFE; step(); ld_valid = 1'b0;
    en = 1'b1; step(); cmp("clr_pre_ff", int'(q0), 8'hFF);
    clr = 1'b1; ld_valid = 1'b1; ld_data = 8'h33; step();
    clr = 1'b0; ld_valid = 1'b0;
    cmp("clr_q", int'(q0), 0); cmp("clr_tc", int'(tc0), 0); cmp("clr_busy", int'(busy0), 0);

    // Reset mid-count at 0x80
    ld_valid = 1'b1; ld_data = 8'h7E; step(); ld_valid = 1'b0;
    step(); step(); cmp("mid_q_80", int'(q0), 8'h80);
    rst = 1'b1; step(); rst = 1'b0;
    cmp("mr_q", int'(q0), 0); cmp("mr_ready", int'(ld_ready0), 1); cmp("mr_tc", int'(tc0), 0);
    step(); cmp("mr_tc2", int'(tc0), 0);

    // Load of all-ones terminates on the first enabled cycle
    ld_valid = 1'b1; ld_data = 8'hFF; ld_auto = 1'b0; step(); ld_valid = 1'b0;
    cmp("ff_cout", int'(cout0), 1);
    step(); cmp("ff_done", int'(done0), 1);

    // Cascade: both stages auto-reload 0xFF
    en = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hFF; ld_auto = 1'b1;
    ld_valid1 = 1'b1; ld_data1 = 8'hFF; ld_auto1 = 1'b1;
    step();
    ld_valid = 1'b0; ld_valid1 = 1'b0;
    cmp("cas_cout_off", int'(cout1), 0);
    en = 1'b1; #1;
    cmp("cas_cout_lo", int'(cout0), 1); cmp("cas_cout_hi", int'(cout1), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("cas_tc_lo", int'(tc0), 1); cmp("cas_tc_hi", int'(tc1), 1);
      cmp("cas_q_hi", int'(q1), 8'hFF);
    end
    en = 1'b0; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
